uart_tx_feeder: RTL
===================

Name: uart_tx_feeder

Overview:
- Byte buffer and launcher sitting directly upstream of the UART transmitter. The image pipeline pushes bytes into it at any rate.
- It stores them in a synchronous FIFO and hands them to the transmitter one at a time. Each byte is launched with a single-cycle o_Tx_DV strobe, and the feeder waits until the transmitter has fully returned to idle before launching the next.
- Decouples bursty pixel output from the fixed UART byte rate (10*CLKS_PER_BIT clocks per byte).

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (16 by default).

Ports:
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Wr_DV  in  1  write strobe; i_Wr_Byte is captured on every clock this is high.
- i_Wr_Byte  in  8  byte to enqueue.
- o_Full  out  1  FIFO holds 2**ADDR_W entries.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- o_Overflow  out  1  sticky; set when a write is dropped, cleared only by reset.
- o_Tx_DV  out  1  one-clock launch strobe to the transmitter.
- o_Tx_Byte  out  8  byte presented with o_Tx_DV; holds its value until the next launch.
- i_Tx_Active  in  1  transmitter busy flag.
- i_Tx_Done  in  1  transmitter done flag.

Behaviour:
- Reset values (i_Reset high at a rising edge):
  - FIFO pointers and count cleared: o_Count=0, o_Empty=1, o_Full=0.
  - o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00, FSM in S_IDLE.
  - FIFO RAM contents need not be cleared.
- Write path:
  - If i_Wr_DV=1 and o_Full=0: the byte goes to mem[wr_ptr], wr_ptr increments and wraps modulo depth, and count increments.
  - If i_Wr_DV=1 and o_Full=1: the byte is dropped, o_Overflow is set to 1, and count is unchanged. This holds even if a pop occurs in the same cycle; the full check uses the registered flag.
- Read path: a pop happens only in S_IDLE with the launch condition true. The pop sets o_Tx_Byte <= mem[rd_ptr], increments rd_ptr with wrap, and decrements count.
- Simultaneous write and pop (not full): count is unchanged and both pointers advance.
- Flags o_Full, o_Empty and o_Count are registered and updated on the same edge as the pointer change.
- Launch condition: o_Empty=0 AND i_Tx_Active=0 AND i_Tx_Done=0. This guards against launching while the transmitter is still in its stop/cleanup phase, including after a reset mid-transfer.
- FSM states:
  - S_IDLE: if the launch condition holds, pop, set o_Tx_DV=1 and go to S_ISSUE; else stay.
  - S_ISSUE: o_Tx_DV returns to 0; go to S_WAIT_ACT.
  - S_WAIT_ACT: if i_Tx_Active=1 go to S_WAIT_IDLE. Timeout: 2 clocks in this state without i_Tx_Active also goes to S_WAIT_IDLE; the byte is considered sent.
  - S_WAIT_IDLE: when i_Tx_Active=0 AND i_Tx_Done=0, go to S_IDLE.
  - Any unused encoding: go to S_IDLE.
- Latency:
  - A byte written at edge N into an empty FIFO, with the transmitter idle, pops at edge N+1; o_Tx_DV is high for the cycle between edges N+1 and N+2.
  - Back-to-back launches are separated by the full transmitter frame plus its done handshake. The feeder never shortens that frame.
- o_Tx_DV is never high for more than one consecutive clock.
- Reset mid-operation: FIFO contents are discarded. A byte already launched finishes on the transmitter independently. The next launch waits, via the launch condition, until the transmitter has returned fully idle.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state localparams S_IDLE=2'd0, S_ISSUE=2'd1, S_WAIT_ACT=2'd2, S_WAIT_IDLE=2'd3.
  - Constant UART_DATA_W=8.
- Sub-module sync_fifo (parameters DATA_W, ADDR_W; ports wr_en/wr_data/rd_en/rd_data/full/empty/count/overflow). The uart_tx_feeder top holds only the FSM and the transmitter interface.

Test Plan:
- Reset then idle: i_Reset for 2 clocks, no writes -> o_Empty=1, o_Count=0, o_Tx_DV never asserted over 100 clocks.
- Single byte, paired with uart_tx at CLKS_PER_BIT=4: write 8'hA5 -> o_Tx_DV pulses exactly once, 2 edges after the write, with o_Tx_Byte=8'hA5; the serial line shows start, bits 1,0,1,0,0,1,0,1 (LSB first), stop; o_Empty=1 afterwards.
- Burst: write 8'h01..8'h05 on 5 consecutive clocks -> o_Count peaks at 4 (the first byte pops on the 2nd edge); 5 launches occur in order 01..05; each o_Tx_DV arrives only after i_Tx_Done has fallen; no overlap on the serial line.
- Overflow: hold the transmitter busy, write 17 bytes (ADDR_W=4) -> o_Full=1 after 16; the 17th is dropped; o_Overflow=1 and stays 1 after draining; the drained sequence equals the first 16 bytes.
- Wrap-around: 40 writes interleaved with draining -> output order matches input order across pointer wrap; o_Count never exceeds 16.
- Reset mid-frame: assert i_Reset during a transmitter data bit with 3 bytes queued -> o_Count=0 next edge and no further launches; a new write after reset launches only once i_Tx_Active=0 and i_Tx_Done=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit feeder: data width and launcher FSM encodings.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_ACT  = 2'd2;
  localparam logic [1:0] S_WAIT_IDLE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/count flags and a sticky overflow flag.
// Read data is the word at the read pointer, valid whenever the FIFO is not empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              do_wr, do_rd;

  // Full is judged on the registered flag, so a write into a full FIFO is dropped even if a pop frees a slot that cycle.
  always_comb begin
    do_wr      = wr_en && !full_q;
    do_rd      = rd_en && !empty_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (wr_en && full_q);
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    else if (!do_wr && do_rd) count_d = count_q - 1'b1;
    full_d  = count_d[ADDR_W];
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes in a FIFO and launches them one at a time into a UART transmitter,
// waiting for the transmitter to return fully idle between launches.
module uart_tx_feeder #(
  parameter int ADDR_W = 4
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  output logic          o_Full,
  output logic          o_Empty,
  output logic [ADDR_W:0] o_Count,
  output logic          o_Overflow,
  output logic          o_Tx_DV,
  output logic [7:0]    o_Tx_Byte,
  input  logic          i_Tx_Active,
  input  logic          i_Tx_Done
);

  import uart_pkg::*;

  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_empty;
  logic                   pop;
  logic                   launch;
  logic [1:0]             state_q, state_d;
  logic                   wait_cnt_q, wait_cnt_d;
  logic                   tx_dv_q, tx_dv_d;
  logic [UART_DATA_W-1:0] tx_byte_q, tx_byte_d;

  sync_fifo #(
    .DATA_W(UART_DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk      (i_Clock),
    .reset    (i_Reset),
    .wr_en    (i_Wr_DV),
    .wr_data  (i_Wr_Byte),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (o_Full),
    .empty    (fifo_empty),
    .count    (o_Count),
    .overflow (o_Overflow)
  );

  // Waiting on both Active and Done low keeps us from launching into the transmitter's cleanup phase.
  always_comb begin
    launch     = !fifo_empty && !i_Tx_Active && !i_Tx_Done;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          pop       = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = fifo_rd_data;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = 1'b0;
        state_d    = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        if (i_Tx_Active || wait_cnt_q) state_d = S_WAIT_IDLE;
        else wait_cnt_d = 1'b1;
      end
      S_WAIT_IDLE: begin
        if (!i_Tx_Active && !i_Tx_Done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign o_Empty   = fifo_empty;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;

endmodule
